// File: rtl/uart_pkg.sv
// uart_pkg: shared constants, state encodings and round-robin helper for the UART transmit scheduler.
package uart_pkg;
    localparam int CLK_HZ     = 100_000_000;
    localparam int BAUD       = 115200;
    localparam int OVERSAMPLE = 16;

    typedef enum logic [1:0] {IDLE, LOAD, SEND, GAP} sched_state_t;
    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PAR, S_STOP} ser_state_t;

    // First set bit of req searching upward from ptr, wrapping at n (n <= 8).
    function automatic logic [2:0] rr_pick(input logic [7:0] req, input logic [2:0] ptr, input int n);
        logic [2:0] pick;
        logic [2:0] k;
        logic       found;
        pick  = ptr;
        found = 1'b0;
        for (int i = 0; i < 8; i++) begin
            k = 3'((int'(ptr) + i) % n);
            if (i < n && !found && req[k]) begin
                pick  = k;
                found = 1'b1;
            end
        end
        return pick;
    endfunction
endpackage

// File: rtl/uart_tx_serializer.sv
// uart_tx_serializer: frames one character per start pulse and shifts it out LSB first, timed by br_tick.
//   clk, reset (async, active-high), br_tick (16x baud strobe)
//   start: one-clk pulse, captures data; the frame begins on the next br_tick
//   tx: serial line, idle high; done: one-clk pulse after the stop bit
//   UART_TX_PARITY_EN: when defined, an even-parity bit precedes the stop bit (8E1)
module uart_tx_serializer import uart_pkg::*; #(
    parameter int DATA_W     = 8,
    parameter int OVERSAMPLE = uart_pkg::OVERSAMPLE
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              br_tick,
    input  logic              start,
    input  logic [DATA_W-1:0] data,
    output logic              tx,
    output logic              done
);
    localparam int TW = $clog2(OVERSAMPLE);
    localparam int BW = $clog2(DATA_W + 3);
`ifdef UART_TX_PARITY_EN
    localparam ser_state_t AFTER_DATA = S_PAR;
`else
    localparam ser_state_t AFTER_DATA = S_STOP;
`endif

    ser_state_t        state, state_n;
    logic [TW-1:0]     tick_cnt, tick_cnt_n;
    logic [BW-1:0]     bit_cnt, bit_cnt_n;
    logic [DATA_W-1:0] sh, sh_n;
    logic              armed, armed_n, tx_n, done_n, tick_end;
`ifdef UART_TX_PARITY_EN
    logic              par, par_n;
`endif

    assign tick_end = br_tick && tick_cnt == TW'(OVERSAMPLE - 1);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= S_IDLE;
            tick_cnt <= '0;
            bit_cnt  <= '0;
            sh       <= '0;
            armed    <= 1'b0;
            tx       <= 1'b1;
            done     <= 1'b0;
`ifdef UART_TX_PARITY_EN
            par      <= 1'b0;
`endif
        end else begin
            state    <= state_n;
            tick_cnt <= tick_cnt_n;
            bit_cnt  <= bit_cnt_n;
            sh       <= sh_n;
            armed    <= armed_n;
            tx       <= tx_n;
            done     <= done_n;
`ifdef UART_TX_PARITY_EN
            par      <= par_n;
`endif
        end
    end

    always_comb begin
        state_n = state;
        done_n  = 1'b0;
        armed_n = start ? 1'b1 : armed;
        case (state)
            S_IDLE: if (armed && br_tick) begin
                state_n = S_START;
                armed_n = 1'b0;
            end
            S_START: if (tick_end) state_n = S_DATA;
            S_DATA:  if (tick_end && bit_cnt == BW'(DATA_W)) state_n = AFTER_DATA;
            S_PAR:   if (tick_end) state_n = S_STOP;
            S_STOP:  if (tick_end) begin
                state_n = S_IDLE;
                done_n  = 1'b1;
            end
            default: state_n = S_IDLE;
        endcase
        // The tick that opens the start bit is not counted; the next OVERSAMPLE ticks close each bit.
        tick_cnt_n = state == S_IDLE ? '0 : tick_end ? '0 : br_tick ? tick_cnt + 1'b1 : tick_cnt;
        bit_cnt_n  = state == S_IDLE ? '0 : tick_end ? bit_cnt + 1'b1 : bit_cnt;
        sh_n       = start ? data : (state == S_DATA && tick_end) ? sh >> 1 : sh;
        tx_n       = state_n == S_START ? 1'b0 : state_n == S_DATA ? sh_n[0] : 1'b1;
`ifdef UART_TX_PARITY_EN
        par_n = start ? ^data : par;
        if (state_n == S_PAR) tx_n = par;
`endif
    end
endmodule

// File: rtl/uart_tx_sched.sv
// uart_tx_sched: round-robin, packet-granular sharing of one UART transmit line between NUM_REQ requesters.
//   clk, reset (async, active-high), br_tick (16x baud strobe)
//   req_valid/req_data/req_last: per-requester byte offers; req_ready: one-hot accept pulse
//   tx: serial line, idle high; busy: grant held or frame/gap in progress; grant_id: current or last grantee
//   UART_TX_PARITY_EN: when defined, frames carry an even-parity bit (8E1)
module uart_tx_sched import uart_pkg::*; #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_W     = 8,
    parameter int OVERSAMPLE = uart_pkg::OVERSAMPLE,
    parameter int IDLE_GAP   = 1
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       br_tick,
    input  logic [NUM_REQ-1:0]         req_valid,
    input  logic [NUM_REQ*DATA_W-1:0]  req_data,
    input  logic [NUM_REQ-1:0]         req_last,
    output logic [NUM_REQ-1:0]         req_ready,
    output logic                       tx,
    output logic                       busy,
    output logic [$clog2(NUM_REQ)-1:0] grant_id
);
    localparam int GW        = $clog2(NUM_REQ);
    localparam int GAP_TICKS = IDLE_GAP * OVERSAMPLE;
    localparam int CW        = $clog2(15 * OVERSAMPLE + 1);

    sched_state_t  state, state_n;
    logic [GW-1:0] rr_ptr, rr_ptr_n, grant_n, next_id;
    logic [CW-1:0] gap_cnt, gap_cnt_n;
    logic          last_q, last_n, accept, ser_done, gap_end;

    assign accept    = state == LOAD && req_valid[grant_id];
    assign req_ready = accept ? NUM_REQ'(1) << grant_id : '0;
    assign busy      = state != IDLE;
    assign next_id   = grant_id == GW'(NUM_REQ - 1) ? '0 : grant_id + 1'b1;
    assign gap_end   = br_tick && gap_cnt == CW'(GAP_TICKS - 1);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            rr_ptr   <= '0;
            grant_id <= '0;
            gap_cnt  <= '0;
            last_q   <= 1'b0;
        end else begin
            state    <= state_n;
            rr_ptr   <= rr_ptr_n;
            grant_id <= grant_n;
            gap_cnt  <= gap_cnt_n;
            last_q   <= last_n;
        end
    end

    always_comb begin
        state_n   = state;
        rr_ptr_n  = rr_ptr;
        grant_n   = grant_id;
        last_n    = accept ? req_last[grant_id] : last_q;
        gap_cnt_n = state != GAP ? '0 : br_tick ? gap_cnt + 1'b1 : gap_cnt;
        case (state)
            IDLE: if (|req_valid) begin
                grant_n = GW'(rr_pick(8'(req_valid), 3'(rr_ptr), NUM_REQ));
                state_n = LOAD;
            end
            LOAD: if (accept) state_n = SEND;
            // Rotation happens only at packet end, so a stalled requester keeps the line.
            SEND: if (ser_done) begin
                state_n  = !last_q ? LOAD : GAP_TICKS == 0 ? IDLE : GAP;
                rr_ptr_n = last_q ? next_id : rr_ptr;
            end
            GAP: if (gap_end) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    uart_tx_serializer #(.DATA_W(DATA_W), .OVERSAMPLE(OVERSAMPLE)) u_ser (
        .clk     (clk),
        .reset   (reset),
        .br_tick (br_tick),
        .start   (accept),
        .data    (req_data[grant_id*DATA_W +: DATA_W]),
        .tx      (tx),
        .done    (ser_done)
    );
endmodule

// File: doc/uart_tx_sched.md
Name: uart_tx_sched

Overview:
Shares a single UART transmit line between NUM_REQ on-chip requesters, e.g. score reporter, pose/debug dump and status beacon.
- Arbitrates round-robin at packet granularity: a grant is held until that requester's last byte.
- Serializes each accepted byte as 8N1, LSB first.
- Bit timing comes from the 16x oversampling br_tick produced by the shared baud generator (100 MHz / 115200 / 16, one pulse every 54 clk).

Parameters:
NUM_REQ, 4, number of requesters (2..8)
DATA_W, 8, bits per UART character
OVERSAMPLE, 16, br_tick pulses per UART bit
IDLE_GAP, 1, idle bit-times inserted between packets from different requesters (0..15)

Ports:
clk  in  1  system clock, 100 MHz
reset  in  1  asynchronous, active-high
br_tick  in  1  single-cycle 16x baud strobe
req_valid  in  NUM_REQ  byte offered by requester i
req_data  in  NUM_REQ*DATA_W  byte i occupies bits [i*DATA_W +: DATA_W]
req_last  in  NUM_REQ  offered byte is last of its packet
req_ready  out  NUM_REQ  byte of requester i accepted this cycle
tx  out  1  serial output, idle high
busy  out  1  grant held or frame in flight
grant_id  out  $clog2(NUM_REQ)  current or most recent grantee

Behaviour:
Interface: clock clk; reset reset, asynchronous, active-high. All state is reset by it.

Reset values:
- tx=1, busy=0, req_ready=0, grant_id=0.
- Round-robin pointer = 0; FSM in IDLE.

Scheduler FSM:
- IDLE: if any req_valid, pick the first set bit searching from rr_ptr upward with wrap; latch grant_id; go to LOAD. Same-cycle arbitration; no wait for br_tick.
- LOAD: if req_valid[grant_id], pulse req_ready[grant_id] for exactly one clk. Capture data into shift_reg and last into last_q; go to SEND. Otherwise stay in LOAD, grant held, tx idle high. A stalling requester keeps the line.
- SEND: serializer runs the frame. On frame end, if last_q: rr_ptr = grant_id+1 mod NUM_REQ, then GAP. Else back to LOAD.
- GAP: hold tx high for IDLE_GAP*OVERSAMPLE br_ticks, then IDLE. IDLE_GAP=0 goes straight to IDLE.

Handshake rules:
- req_ready is one-hot or zero and never asserted outside LOAD.
- Data is sampled only in the cycle req_ready is high.
- Non-granted requesters' valid/data/last are ignored and may change freely.

Serializer timing (counts br_tick only; clk cycles between ticks are ignored):
- Start bit 0, then DATA_W data bits LSB first, then stop bit 1. Each bit lasts exactly OVERSAMPLE ticks.
- tx changes in the clk cycle after the br_tick that closes the previous bit.
- The start bit begins on the first br_tick after entering SEND. Worst-case start latency is one br_tick period.
- Counters: tick_cnt $clog2(OVERSAMPLE) bits, wraps at OVERSAMPLE-1; bit_cnt $clog2(DATA_W+3) bits.

busy: high from leaving IDLE until GAP completes.

Boundary conditions:
- Only grantee requesting: re-granted after GAP.
- All requesters valid: service order from reset is 0,1,2,3,0.
- req_valid dropping mid-packet: grant held, no timeout.
- req_valid and req_last on a single-byte packet: one frame, then rotate.
- br_tick asserted in the same cycle as LOAD: ignored by the serializer (SEND not yet entered).
- Reset mid-frame: tx=1 on the next edge; the partial frame is abandoned.

Optional Feature:
UART_TX_PARITY_EN
- Defined: an even-parity bit (XOR of data bits) is inserted between the last data bit and the stop bit. Frame is 8E1, 11 bits; bit_cnt range grows accordingly.
- Undefined: 8N1, 10-bit frame, no parity logic synthesized.

Decomposition:
Package uart_pkg:
- CLK_HZ=100_000_000, BAUD=115200, OVERSAMPLE=16.
- Enum sched_state_t {IDLE, LOAD, SEND, GAP}.
- Enum ser_state_t {S_IDLE, S_START, S_DATA, S_PAR, S_STOP}.
- Function rr_pick(req, ptr) returning the next grantee index.

Sub-module uart_tx_serializer, instantiated once:
- Inputs: br_tick, start, data.
- Outputs: tx, done (1-clk pulse).
- Contains tick_cnt, bit_cnt and the parity logic.

The scheduler keeps arbitration, rr_ptr, grant and gap counting.

Test Plan:
1. Reset, then req_valid=0001, data 0x55, last=1 -> req_ready[0] one pulse. tx low 864±54 clk, then 1,0,1,0,1,0,1,0, stop. Frame 8640 clk. busy drops after gap (864 clk).
2. req_valid=1111, each requester sends one-byte packets 0xA0+i -> frames observed in order 0xA0,0xA1,0xA2,0xA3,0xA0. grant_id follows 0,1,2,3,0.
3. Req1 sends 3-byte packet 0x11,0x22,0x33 (last on 0x33) while req0 holds valid -> three back-to-back req1 frames with no gap, then gap, then req0.
4. Req2 drops valid for 20000 clk between bytes 1 and 2 of a packet -> tx held high, busy=1, grant_id=2. req_ready stays 0 for others. Resumes with byte 2.
5. Assert reset 3000 clk into a frame -> tx=1 one cycle later, busy=0, req_ready=0. Next packet starts cleanly with grant to requester 0.
6. With UART_TX_PARITY_EN, send 0x07 -> parity bit 1, 11-bit frame (9504 clk). Without the macro, the same byte gives a 10-bit frame.
